// File: rtl/ddr2_sdram_ex_lfsr8_checker.sv
// rtl/ddr2_sdram_ex_lfsr8_checker.sv - per-lane 8-bit LFSR read-data checker with seeded or self-sync lock.
// Optional first-error capture ports: define LFSR8_CHECKER_FIRST_ERR_EN.
module ddr2_sdram_ex_lfsr8_checker #(
    parameter int LANES       = 4,
    parameter int SEED        = 32,
    parameter int SYNC_THRESH = 4,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 self_sync,
    input  logic                 rd_valid,
    input  logic [8*LANES-1:0]   rd_data,
    output logic                 locked,
    output logic                 error,
    output logic [LANES-1:0]     lane_err,
    output logic [CNT_W-1:0]     err_count,
`ifdef LFSR8_CHECKER_FIRST_ERR_EN
    output logic [8*LANES-1:0]   first_err_data,
    output logic [8*LANES-1:0]   first_err_exp,
    output logic [CNT_W-1:0]     first_err_beat,
`endif
    output logic [CNT_W-1:0]     beat_count
);

    typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

    state_t               state_q;
    logic [8*LANES-1:0]   exp_q;
    logic [7:0]           match_run_q;
    logic [7:0]           miss_run_q;
    logic                 loaded_q;
    logic                 mode_q;
    logic                 locked_q;
    logic                 error_q;
    logic [LANES-1:0]     lane_err_q;
    logic [CNT_W-1:0]     err_count_q;
    logic [CNT_W-1:0]     beat_count_q;

    logic [8*LANES-1:0]   seed_d;
    logic [8*LANES-1:0]   exp_step_d;
    logic [8*LANES-1:0]   data_step_d;
    logic [LANES-1:0]     lane_mis_d;
    logic                 any_mis_d;
    logic [7:0]           match_inc_d;
    logic [7:0]           miss_inc_d;

`ifdef LFSR8_CHECKER_FIRST_ERR_EN
    logic [8*LANES-1:0]   first_err_data_q;
    logic [8*LANES-1:0]   first_err_exp_q;
    logic [CNT_W-1:0]     first_err_beat_q;
`endif

    // x^8+x^4+x^3+x^2+1, Galois-style feedback of d7 into taps 2,3,4
    function automatic logic [7:0] lfsr_step(input logic [7:0] d);
        return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
    endfunction

    always_comb begin
        seed_d      = '0;
        exp_step_d  = '0;
        data_step_d = '0;
        lane_mis_d  = '0;
        for (int l = 0; l < LANES; l++) begin
            seed_d[8*l +: 8]      = 8'(SEED + l);
            exp_step_d[8*l +: 8]  = lfsr_step(exp_q[8*l +: 8]);
            data_step_d[8*l +: 8] = lfsr_step(rd_data[8*l +: 8]);
            lane_mis_d[l]         = rd_data[8*l +: 8] != exp_q[8*l +: 8];
        end
        any_mis_d   = |lane_mis_d;
        match_inc_d = match_run_q + 8'd1;
        miss_inc_d  = miss_run_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            exp_q        <= seed_d;
            match_run_q  <= '0;
            miss_run_q   <= '0;
            loaded_q     <= 1'b0;
            mode_q       <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            lane_err_q   <= '0;
            err_count_q  <= '0;
            beat_count_q <= '0;
`ifdef LFSR8_CHECKER_FIRST_ERR_EN
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            first_err_beat_q <= '0;
`endif
        end else if (!enable) begin
            // status and counts are left for the pass/fail logic to read
            state_q     <= IDLE;
            exp_q       <= seed_d;
            match_run_q <= '0;
            miss_run_q  <= '0;
            loaded_q    <= 1'b0;
            locked_q    <= 1'b0;
        end else if (start) begin
            state_q      <= self_sync ? SYNC : CHECK;
            locked_q     <= !self_sync;
            mode_q       <= self_sync;
            exp_q        <= seed_d;
            match_run_q  <= '0;
            miss_run_q   <= '0;
            loaded_q     <= 1'b0;
            error_q      <= 1'b0;
            lane_err_q   <= '0;
            err_count_q  <= '0;
            beat_count_q <= '0;
`ifdef LFSR8_CHECKER_FIRST_ERR_EN
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            first_err_beat_q <= '0;
`endif
        end else if (rd_valid) begin
            case (state_q)
                IDLE: begin
                end
                SYNC: begin
                    if (!loaded_q || any_mis_d) begin
                        exp_q       <= data_step_d;
                        match_run_q <= '0;
                        loaded_q    <= 1'b1;
                    end else begin
                        exp_q       <= exp_step_d;
                        match_run_q <= match_inc_d;
                        if (match_inc_d == 8'(SYNC_THRESH)) begin
                            state_q    <= CHECK;
                            locked_q   <= 1'b1;
                            miss_run_q <= '0;
                        end
                    end
                end
                CHECK: begin
                    exp_q <= exp_step_d;
                    if (beat_count_q != '1) beat_count_q <= beat_count_q + 1'b1;
                    if (any_mis_d) begin
                        error_q    <= 1'b1;
                        lane_err_q <= lane_err_q | lane_mis_d;
                        if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
`ifdef LFSR8_CHECKER_FIRST_ERR_EN
                        if (!error_q) begin
                            first_err_data_q <= rd_data;
                            first_err_exp_q  <= exp_q;
                            first_err_beat_q <= beat_count_q;
                        end
`endif
                    end
                    if (mode_q) begin
                        if (!any_mis_d) begin
                            miss_run_q <= '0;
                        end else if (miss_inc_d == 8'(LOSS_THRESH)) begin
                            state_q     <= SYNC;
                            locked_q    <= 1'b0;
                            loaded_q    <= 1'b0;
                            miss_run_q  <= '0;
                            match_run_q <= '0;
                        end else begin
                            miss_run_q <= miss_inc_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign lane_err   = lane_err_q;
    assign err_count  = err_count_q;
    assign beat_count = beat_count_q;
`ifdef LFSR8_CHECKER_FIRST_ERR_EN
    assign first_err_data = first_err_data_q;
    assign first_err_exp  = first_err_exp_q;
    assign first_err_beat = first_err_beat_q;
`endif

endmodule

// File: tb/tb_ddr2_sdram_ex_lfsr8_checker.sv
// tb/tb_ddr2_sdram_ex_lfsr8_checker.sv - directed bench for the LFSR8 read checker.
module tb_ddr2_sdram_ex_lfsr8_checker;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        start;
    logic        self_sync;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        locked, error;
    logic [3:0]  lane_err;
    logic [15:0] err_count, beat_count;
    logic        locked4, error4;
    logic [3:0]  lane_err4;
    logic [3:0]  err_count4, beat_count4;
`ifdef LFSR8_CHECKER_FIRST_ERR_EN
    logic [31:0] fed, fee, fed4, fee4;
    logic [15:0] feb;
    logic [3:0]  feb4;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] ln [4];

    ddr2_sdram_ex_lfsr8_checker u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
        .self_sync(self_sync), .rd_valid(rd_valid), .rd_data(rd_data),
        .locked(locked), .error(error), .lane_err(lane_err),
        .err_count(err_count),
`ifdef LFSR8_CHECKER_FIRST_ERR_EN
        .first_err_data(fed), .first_err_exp(fee), .first_err_beat(feb),
`endif
        .beat_count(beat_count)
    );

    ddr2_sdram_ex_lfsr8_checker #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
        .self_sync(self_sync), .rd_valid(rd_valid), .rd_data(rd_data),
        .locked(locked4), .error(error4), .lane_err(lane_err4),
        .err_count(err_count4),
`ifdef LFSR8_CHECKER_FIRST_ERR_EN
        .first_err_data(fed4), .first_err_exp(fee4), .first_err_beat(feb4),
`endif
        .beat_count(beat_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] step8(input logic [7:0] d);
        return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
    endfunction

    function automatic logic [31:0] cur_beat();
        return {ln[3], ln[2], ln[1], ln[0]};
    endfunction

    task automatic adv();
        for (int l = 0; l < 4; l++) ln[l] = step8(ln[l]);
    endtask

    task automatic seed_lanes(input logic [7:0] b, input logic same);
        for (int l = 0; l < 4; l++) ln[l] = same ? b : b + 8'(l);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt = total_cnt + 1;
        assert (obs === expv) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic cyc(input logic st, input logic v, input logic [31:0] d);
        start    = st;
        rd_valid = v;
        rd_data  = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, cur_beat());
            adv();
        end
    endtask

    task automatic bad(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, ~cur_beat());
            adv();
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; start = 1'b0; self_sync = 1'b0;
        rd_valid = 1'b0; rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_lane_err", 32'(lane_err), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_beat_count", 32'(beat_count), 32'h0);
        reset_n = 1'b1;

        cyc(1'b0, 1'b1, 32'h1234_5678);
        chk("idle_ignores_beat", 32'(beat_count), 32'h0);

        // 1: seeded clean run; start beat carries garbage that must be dropped
        seed_lanes(8'h20, 1'b0);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("t1_locked_at_start", 32'(locked), 32'h1);
        chk("t1_start_beat_dropped", 32'(beat_count), 32'h0);
        clean(100);
        chk("t1_beat_count", 32'(beat_count), 32'd100);
        chk("t1_err_count", 32'(err_count), 32'h0);
        chk("t1_error", 32'(error), 32'h0);

        // 2: restart, single bit flip in lane 2 on beat 10
        seed_lanes(8'h20, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t2_restart_clears", 32'(beat_count), 32'h0);
        clean(10);
        cyc(1'b0, 1'b1, cur_beat() ^ 32'h0001_0000);
        adv();
        clean(89);
        chk("t2_err_count", 32'(err_count), 32'd1);
        chk("t2_lane_err", 32'(lane_err), 32'h4);
        chk("t2_error", 32'(error), 32'h1);
        chk("t2_locked", 32'(locked), 32'h1);
        chk("t2_beat_count", 32'(beat_count), 32'd100);

        // 3: self-sync on a stream starting at 0xA5 in every lane
        self_sync = 1'b1;
        seed_lanes(8'hA5, 1'b1);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t3_not_locked_at_start", 32'(locked), 32'h0);
        chk("t3_error_cleared", 32'(error), 32'h0);
        clean(4);
        chk("t3_not_locked_beat4", 32'(locked), 32'h0);
        clean(1);
        chk("t3_locked_beat5", 32'(locked), 32'h1);
        chk("t3_no_count_in_sync", 32'(beat_count), 32'h0);
        clean(10);
        chk("t3_beat_count", 32'(beat_count), 32'd10);
        chk("t3_err_count", 32'(err_count), 32'h0);

        // 4: loss of lock after 8 bad beats, then relock
        bad(7);
        chk("t4_locked_after_7", 32'(locked), 32'h1);
        chk("t4_err_after_7", 32'(err_count), 32'd7);
        bad(1);
        chk("t4_unlocked_after_8", 32'(locked), 32'h0);
        chk("t4_err_after_8", 32'(err_count), 32'd8);
        chk("t4_beat_after_8", 32'(beat_count), 32'd18);
        chk("t4_lane_err", 32'(lane_err), 32'hF);
        clean(4);
        chk("t4_not_relocked_4", 32'(locked), 32'h0);
        clean(1);
        chk("t4_relocked_5", 32'(locked), 32'h1);
        chk("t4_beat_held_sync", 32'(beat_count), 32'd18);
        clean(1);
        chk("t4_beat_resumes", 32'(beat_count), 32'd19);
        chk("t4_err_holds", 32'(err_count), 32'd8);

        // 5: saturation with a 4-bit counter instance
        self_sync = 1'b0;
        seed_lanes(8'h20, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        bad(20);
        chk("t5_err_sat", 32'(err_count4), 32'hF);
        chk("t5_beat_sat", 32'(beat_count4), 32'hF);
        chk("t5_lane_err4", 32'(lane_err4), 32'hF);
        chk("t5_err_wide", 32'(err_count), 32'd20);
        chk("t5_seeded_stays_locked", 32'(locked), 32'h1);

        // 6: enable low, then asynchronous reset mid-cycle
        enable = 1'b0;
        cyc(1'b0, 1'b1, cur_beat());
        chk("t6_en_unlocked", 32'(locked), 32'h0);
        chk("t6_en_err_held", 32'(err_count), 32'd20);
        chk("t6_en_beat_held", 32'(beat_count), 32'd20);
        chk("t6_en_error_held", 32'(error), 32'h1);
        enable = 1'b1;
        cyc(1'b0, 1'b1, 32'h2040_80A0);
        chk("t6_idle_after_en", 32'(beat_count), 32'd20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_locked", 32'(locked), 32'h0);
        chk("t6_rst_error", 32'(error), 32'h0);
        chk("t6_rst_lane_err", 32'(lane_err), 32'h0);
        chk("t6_rst_err_count", 32'(err_count), 32'h0);
        chk("t6_rst_beat_count", 32'(beat_count), 32'h0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b1, 32'h0);
        chk("t6_idle_after_rst", 32'(locked), 32'h0);
        seed_lanes(8'h20, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        clean(3);
        chk("t6_restart_beats", 32'(beat_count), 32'd3);
        chk("t6_restart_clean", 32'(err_count), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
